// File: rtl/ecrc_stream_generator_if.sv
// ecrc_stream_generator_if: beat input, ECRC output handshake and busy flag of the ECRC generator
interface ecrc_stream_generator_if #(
  parameter int DATA_WIDTH = 256,
  parameter int LENGTH_WIDTH = 4,
  parameter int POLY_WIDTH = 32
);
  logic CRC_i_Valid;
  logic CRC_i_SOP;
  logic CRC_i_EOP;
  logic [DATA_WIDTH-1:0] CRC_i_Message;
  logic [LENGTH_WIDTH-1:0] CRC_i_Length;
  logic CRC_o_Ready;
  logic CRC_o_Valid;
  logic CRC_i_Out_Ready;
  logic [POLY_WIDTH-1:0] CRC_o_ECRC;
  logic CRC_o_Busy;
  modport master (
    output CRC_i_Valid, CRC_i_SOP, CRC_i_EOP, CRC_i_Message, CRC_i_Length, CRC_i_Out_Ready,
    input CRC_o_Ready, CRC_o_Valid, CRC_o_ECRC, CRC_o_Busy
  );
  modport slave (
    input CRC_i_Valid, CRC_i_SOP, CRC_i_EOP, CRC_i_Message, CRC_i_Length, CRC_i_Out_Ready,
    output CRC_o_Ready, CRC_o_Valid, CRC_o_ECRC, CRC_o_Busy
  );
endinterface

// File: rtl/ecrc_stream_generator.sv
// ecrc_stream_generator: PCIe ECRC (reflected CRC-32) over multi-beat TLPs, held under a valid/ready handshake
// ports: clk, arst (async active-high); bus.slave carries beat input (Valid/SOP/EOP/Message/Length, Ready),
// ECRC output (Valid/ECRC, Out_Ready) and Busy
module ecrc_stream_generator #(
  parameter int DATA_WIDTH = 256,
  parameter int DW_COUNT = DATA_WIDTH / 32,
  parameter int LENGTH_WIDTH = 4,
  parameter int POLY_WIDTH = 32,
  parameter bit VARIANT_MASK_EN = 1
) (
  input logic clk,
  input logic arst,
  ecrc_stream_generator_if.slave bus
);
  // 0x04C11DB7 bit-reversed, for LSB-first shifting
  localparam logic [POLY_WIDTH-1:0] POLY_R = 32'hEDB8_8320;
  // Type[0] (byte0 bit0) and EP (byte2 bit6) forced to 1 on the SOP beat
  localparam logic [DATA_WIDTH-1:0] VARIANT_BITS = DATA_WIDTH'(32'h0040_0001);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  state_t state, state_n;
  logic [POLY_WIDTH-1:0] crc, crc_n, ecrc, ecrc_n, base, folded;
  logic [DATA_WIDTH-1:0] msg;
  logic [LENGTH_WIDTH-1:0] len;
  logic take, leave;
  function automatic logic [POLY_WIDTH-1:0] fold(input logic [POLY_WIDTH-1:0] c_in,
                                                  input logic [DATA_WIDTH-1:0] d,
                                                  input logic [LENGTH_WIDTH-1:0] n);
    logic [POLY_WIDTH-1:0] c;
    c = c_in;
    for (int i = 0; i < DATA_WIDTH; i++)
      if (i < 32 * int'(n)) c = {1'b0, c[POLY_WIDTH-1:1]} ^ ((c[0] ^ d[i]) ? POLY_R : '0);
    return c;
  endfunction
  always_comb begin
    // beats without SOP are only meaningful while a TLP is open
    take = bus.CRC_i_Valid & bus.CRC_o_Ready & (bus.CRC_i_SOP | (state == ACCUM));
    leave = (state == HOLD) & bus.CRC_i_Out_Ready;
    len = (bus.CRC_i_Length > LENGTH_WIDTH'(DW_COUNT)) ? LENGTH_WIDTH'(DW_COUNT) : bus.CRC_i_Length;
    msg = bus.CRC_i_Message | ((VARIANT_MASK_EN && bus.CRC_i_SOP) ? VARIANT_BITS : '0);
    base = bus.CRC_i_SOP ? '1 : crc;
    folded = fold(base, msg, len);
    state_n = leave ? IDLE : take ? (bus.CRC_i_EOP ? HOLD : ACCUM) : state;
    crc_n = leave ? '1 : take ? folded : crc;
    ecrc_n = (take & bus.CRC_i_EOP) ? ~folded : ecrc;
  end
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state <= IDLE;
      crc <= '1;
      ecrc <= '0;
    end else begin
      state <= state_n;
      crc <= crc_n;
      ecrc <= ecrc_n;
    end
  end
  assign bus.CRC_o_Ready = state != HOLD;
  assign bus.CRC_o_Valid = state == HOLD;
  assign bus.CRC_o_Busy = state != IDLE;
  assign bus.CRC_o_ECRC = ecrc;
endmodule

// File: tb/tb_ecrc_stream_generator.sv
// tb_ecrc_stream_generator: unmasked and masked generators driven in lockstep, checked against a byte-queue CRC-32 model
module tb_ecrc_stream_generator;
  logic clk = 0;
  logic arst = 1;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] tbl [256];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  int m = 0;
  logic [31:0] e0 = 0;
  logic [31:0] e1 = 0;
  logic [31:0] ea;
  logic [255:0] z, r, a, b;
  ecrc_stream_generator_if #(.DATA_WIDTH(256)) if0 ();
  ecrc_stream_generator_if #(.DATA_WIDTH(256)) if1 ();
  ecrc_stream_generator #(.VARIANT_MASK_EN(0)) u0 (.clk(clk), .arst(arst), .bus(if0));
  ecrc_stream_generator #(.VARIANT_MASK_EN(1)) u1 (.clk(clk), .arst(arst), .bus(if1));
  assign if1.CRC_i_Valid = if0.CRC_i_Valid;
  assign if1.CRC_i_SOP = if0.CRC_i_SOP;
  assign if1.CRC_i_EOP = if0.CRC_i_EOP;
  assign if1.CRC_i_Message = if0.CRC_i_Message;
  assign if1.CRC_i_Length = if0.CRC_i_Length;
  assign if1.CRC_i_Out_Ready = if0.CRC_i_Out_Ready;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] crc32(input logic [7:0] q [$]);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (q[i]) c = tbl[c[7:0] ^ q[i]] ^ (c >> 8);
    return ~c;
  endfunction
  task automatic rand_msg(output logic [255:0] msg);
    for (int i = 0; i < 8; i++) msg[32*i +: 32] = $urandom();
  endtask
  task automatic post_checks();
    check("valid0", if0.CRC_o_Valid, m == 2);
    check("valid1", if1.CRC_o_Valid, m == 2);
    check("busy0", if0.CRC_o_Busy, m != 0);
    check("ecrc0", if0.CRC_o_ECRC, e0);
    check("ecrc1", if1.CRC_o_ECRC, e1);
  endtask
  task automatic do_reset();
    @(negedge clk);
    if0.CRC_i_Valid = 0;
    if0.CRC_i_SOP = 0;
    if0.CRC_i_EOP = 0;
    if0.CRC_i_Length = 0;
    if0.CRC_i_Message = '0;
    if0.CRC_i_Out_Ready = 0;
    #1 arst = 1;
    #1 arst = 0;
    m = 0;
    e0 = 0;
    e1 = 0;
    q0.delete();
    q1.delete();
    #1;
    post_checks();
    check("rst_ready", if0.CRC_o_Ready, 1);
  endtask
  task automatic cycle(input logic v, input logic sop, input logic eop, input logic [3:0] len,
                       input logic [255:0] msg, input logic ordy);
    int n;
    logic [7:0] bv;
    @(negedge clk);
    if0.CRC_i_Valid = v;
    if0.CRC_i_SOP = sop;
    if0.CRC_i_EOP = eop;
    if0.CRC_i_Length = len;
    if0.CRC_i_Message = msg;
    if0.CRC_i_Out_Ready = ordy;
    #1;
    check("ready0", if0.CRC_o_Ready, m != 2);
    check("ready1", if1.CRC_o_Ready, m != 2);
    n = (len > 8) ? 8 : int'(len);
    if (m == 2) begin
      if (ordy) m = 0;
    end else if (v && (sop || m == 1)) begin
      if (sop) begin
        q0.delete();
        q1.delete();
      end
      for (int k = 0; k < 4 * n; k++) begin
        bv = msg[8*k +: 8];
        q0.push_back(bv);
        q1.push_back((sop && k == 0) ? (bv | 8'h01) : (sop && k == 2) ? (bv | 8'h40) : bv);
      end
      if (eop) begin
        m = 2;
        e0 = crc32(q0);
        e1 = crc32(q1);
      end else m = 1;
    end
    @(posedge clk);
    #1;
    post_checks();
  endtask
  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [31:0] c;
      c = 32'(i);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      tbl[i] = c;
    end
    z = '0;
    do_reset();
    cycle(1, 1, 1, 1, z, 0);
    check("zero_dw", if0.CRC_o_ECRC, 32'h2144_DF1C);
    cycle(0, 0, 0, 0, z, 1);
    r = {224'b0, 32'hFFFF_FFFF};
    cycle(1, 1, 1, 1, r, 1);
    check("ones_dw", if0.CRC_o_ECRC, 32'hFFFF_FFFF);
    cycle(0, 0, 0, 0, z, 1);
    cycle(1, 1, 0, 1, z, 0);
    cycle(1, 0, 1, 1, z, 0);
    check("two_beats", if0.CRC_o_ECRC, 32'h6522_DF69);
    cycle(0, 0, 0, 0, z, 1);
    cycle(1, 1, 1, 2, z, 0);
    check("len2", if0.CRC_o_ECRC, 32'h6522_DF69);
    cycle(0, 0, 0, 0, z, 1);
    cycle(1, 1, 0, 1, z, 0);
    cycle(0, 1, 1, 5, r, 0);
    cycle(1, 0, 1, 1, z, 0);
    check("gap", if0.CRC_o_ECRC, 32'h6522_DF69);
    cycle(0, 0, 0, 0, z, 1);
    rand_msg(r);
    cycle(1, 1, 1, 0, r, 0);
    check("len0", if0.CRC_o_ECRC, 32'h0);
    cycle(0, 0, 0, 0, z, 1);
    cycle(1, 1, 1, 3, r, 0);
    rand_msg(r);
    for (int i = 0; i < 5; i++) cycle(1, 1, 1, 12, r, 0);
    cycle(1, 1, 1, 12, r, 1);
    cycle(1, 1, 1, 12, r, 0);
    cycle(0, 0, 0, 0, z, 1);
    rand_msg(a);
    a[0] = 0;
    a[22] = 0;
    b = a;
    b[0] = 1;
    b[22] = 1;
    cycle(1, 1, 1, 8, a, 0);
    ea = e1;
    cycle(0, 0, 0, 0, z, 1);
    cycle(1, 1, 1, 8, b, 0);
    check("variant", if1.CRC_o_ECRC, ea);
    cycle(0, 0, 0, 0, z, 1);
    cycle(1, 1, 0, 3, r, 0);
    do_reset();
    cycle(0, 0, 1, 1, z, 1);
    cycle(1, 1, 1, 1, z, 0);
    check("clean_after_rst", if0.CRC_o_ECRC, 32'h2144_DF1C);
    cycle(0, 0, 0, 0, z, 1);
    for (int i = 0; i < 400; i++) begin
      rand_msg(r);
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
            4'($urandom_range(0, 15)), r, $urandom_range(0, 2) != 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ecrc_stream_generator.md
Name: ecrc_stream_generator

Overview:
- Clocked, parametrised ECRC generator for the TL TX data-fragmentation path.
- Accumulates the PCIe ECRC (CRC-32, poly 0x04C11DB7) over a multi-beat TLP presented DATA_WIDTH bits per cycle, with a per-beat DW count.
- Masks the ECRC variant bits on the first beat.
- Holds the final ECRC under an output valid/ready handshake until the downstream framer accepts it.

Parameters:
- DATA_WIDTH, 256, beat width in bits; multiple of 32.
- DW_COUNT, DATA_WIDTH/32, DWs per beat.
- LENGTH_WIDTH, 4, width of the per-beat DW count; must hold DW_COUNT.
- POLY_WIDTH, 32, CRC width; fixed at 32.
- VARIANT_MASK_EN, 1, 1 = force header variant bits to 1 before CRC on the SOP beat.

Ports:
- clk  in  1  clock
- arst  in  1  asynchronous active-high reset
- CRC_i_Valid  in  1  beat valid
- CRC_i_SOP  in  1  first beat of TLP
- CRC_i_EOP  in  1  last beat of TLP
- CRC_i_Message  in  DATA_WIDTH  beat data; byte k = bits [8k+7:8k], DW0 in low bits, byte 0 transmitted first
- CRC_i_Length  in  LENGTH_WIDTH  valid DWs in beat, taken from DW0 upward
- CRC_o_Ready  out  1  block accepts a beat this cycle
- CRC_o_Valid  out  1  ECRC available
- CRC_i_Out_Ready  in  1  downstream accepts ECRC
- CRC_o_ECRC  out  POLY_WIDTH  final ECRC; byte 0 to transmit = bits [7:0]
- CRC_o_Busy  out  1  a TLP is in progress (ACCUM or HOLD)

Behaviour:
- Single clock domain. arst asserted at any time → state IDLE, running CRC = 32'hFFFF_FFFF, CRC_o_Valid = 0, CRC_o_ECRC = 0, CRC_o_Busy = 0, CRC_o_Ready = 1. A TLP in flight is discarded.
- CRC arithmetic:
  - Reflected CRC-32 over bytes in transmission order, LSB of each byte first. Identical to IEEE 802.3/zlib crc32.
  - Seed 32'hFFFF_FFFF; final value bitwise inverted.
  - One beat is folded per accepted cycle, combinationally across Length DWs, then registered.
- Length rules:
  - Length 0 → CRC unchanged, but SOP/EOP are still honoured.
  - Length > DW_COUNT is clamped to DW_COUNT.
- Variant mask: when VARIANT_MASK_EN=1 and the beat is SOP, byte0 bit0 (Type[0]) and byte2 bit6 (EP) are treated as 1 for the CRC only. Data is not modified.
- Accept condition: CRC_i_Valid & CRC_o_Ready. Beats with Valid=0 are ignored.
- CRC_o_Ready = 0 only in HOLD.
- FSM:
  - IDLE:
    - Accepted SOP&EOP → fold from seed, go to HOLD.
    - Accepted SOP only → fold from seed, go to ACCUM.
    - Accepted beat without SOP → dropped; state unchanged.
  - ACCUM:
    - Accepted non-SOP beat → fold into running CRC.
    - If that beat also has EOP → go to HOLD.
    - Accepted SOP beat (restart) → fold from seed; running TLP abandoned, no ECRC output. If it also has EOP → HOLD.
  - HOLD:
    - CRC_o_Valid = 1; CRC_o_ECRC stable.
    - On CRC_i_Out_Ready = 1 → CRC_o_Valid = 0 next cycle, running CRC re-seeded, go to IDLE.
    - Inputs are not accepted during HOLD.
- Latency: CRC_o_Valid rises on the cycle after the EOP beat is accepted; minimum 1 clk.
- Throughput: a new SOP is accepted on the cycle after the HOLD handshake completes, giving 1 idle cycle between TLPs.
- CRC_o_ECRC keeps its last value after leaving HOLD until the next EOP.
- CRC_o_Busy = (state != IDLE).

Test Plan:
- Reset/default (VARIANT_MASK_EN=0): after arst → CRC_o_Valid=0, CRC_o_Ready=1, CRC_o_ECRC=0.
- Single beat, SOP=EOP=1, Length=1, Message=0 → next cycle CRC_o_Valid=1, CRC_o_ECRC=32'h2144_DF1C; with CRC_i_Out_Ready=1, Valid drops the following cycle.
- Single beat, Length=1, DW0=32'hFFFF_FFFF → CRC_o_ECRC=32'hFFFF_FFFF.
- Two beats of zeros, Length=1 each (SOP on beat 1, EOP on beat 2) → 32'h6522_DF69. The same result is required with Length=2 in one SOP/EOP beat. A Valid=0 gap between the two beats leaves the result unchanged.
- Backpressure: hold CRC_i_Out_Ready=0 for 5 cycles after EOP → CRC_o_Valid stays 1, ECRC stable, CRC_o_Ready=0 and the offered SOP beat is not consumed. Release → IDLE, then the beat is accepted.
- Variant mask (VARIANT_MASK_EN=1): two SOP/EOP TLPs that differ only in byte0 bit0 and byte2 bit6 → identical CRC_o_ECRC. Additionally:
  - arst mid-TLP (ACCUM) → no CRC_o_Valid.
  - A subsequent clean TLP gives the reference value.
